// File: rtl/matrix_a_feeder_if.sv
// Load/feed bus of the A-operand feeder: row-wide load port in, skewed
// per-row feed port out toward the left edge of the PE grid.
interface matrix_a_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 5,
  parameter int ARRAY_L    = 2
);
  logic                          load_valid;
  logic                          load_ready;
  logic [ARRAY_L*DATA_WIDTH-1:0] load_row;
  logic [ARRAY_W*DATA_WIDTH-1:0] feed_data;
  logic [ARRAY_W-1:0]            feed_valid;

  modport master (
    output load_valid, load_row,
    input  load_ready, feed_data, feed_valid
  );

  modport slave (
    input  load_valid, load_row,
    output load_ready, feed_data, feed_valid
  );
endinterface

// File: rtl/matrix_a_feeder.sv
// A-operand feeder: buffers an ARRAY_W x ARRAY_L matrix and streams it with
// diagonal skew. Optional replay mode: define MATRIX_FEEDER_REPLAY_EN.
module matrix_a_feeder_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_L    = 2,
  parameter int KW         = 1,
  parameter int ROW        = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          step_en,
  input  logic [KW-1:0]                 step,
  input  logic [ARRAY_L*DATA_WIDTH-1:0] row,
  output logic [DATA_WIDTH-1:0]         data,
  output logic                          valid
);
  logic [DATA_WIDTH-1:0] data_nx;
  logic                  valid_nx;

  // Row ROW shows column c at step ROW+c; outside that window the slot is idle.
  always_comb begin
    data_nx  = '0;
    valid_nx = 1'b0;
    if (step_en) begin
      for (int j = 0; j < ARRAY_L; j++) begin
        if (step == KW'(ROW + j)) begin
          data_nx  = row[j*DATA_WIDTH +: DATA_WIDTH];
          valid_nx = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      data  <= data_nx;
      valid <= valid_nx;
    end
  end
endmodule

module matrix_a_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 5,
  parameter int ARRAY_L    = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic start,
  output logic busy,
  output logic full,
  output logic done,
`ifdef MATRIX_FEEDER_REPLAY_EN
  output logic [7:0] replay_count,
`endif
  matrix_a_feeder_if.slave bus
);
  localparam int STEPS = ARRAY_L + ARRAY_W - 1;
  localparam int PW    = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1;
  localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [PW-1:0] LAST_ROW = PW'(ARRAY_W - 1);
  localparam logic [KW-1:0] LAST_K   = KW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FULL, FEED} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] row_ptr, ptr_nx;
  logic [KW-1:0] k, k_nx;
  logic          done_nx;
  logic          wr_en;
  logic          step_en;
  logic [KW-1:0] step;

  logic [ARRAY_W-1:0][ARRAY_L*DATA_WIDTH-1:0] mem;
  logic [ARRAY_W-1:0][DATA_WIDTH-1:0]         lane_data;
  logic [ARRAY_W-1:0]                         lane_vld;

  assign bus.load_ready = (state == IDLE) || (state == LOAD);
  assign busy           = (state == FEED);
  assign full           = (state == FULL);
  assign wr_en          = bus.load_valid && bus.load_ready && !clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      row_ptr <= '0;
      k       <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      row_ptr <= ptr_nx;
      k       <= k_nx;
      done    <= done_nx;
    end
  end

  // step/step_en select what the lane registers show next cycle, so the
  // feed output for step k is visible while the FSM sits at step k.
  always_comb begin
    state_nx = state;
    ptr_nx   = row_ptr;
    k_nx     = k;
    done_nx  = 1'b0;
    step_en  = 1'b0;
    step     = '0;
    if (clear) begin
      state_nx = IDLE;
      ptr_nx   = '0;
      k_nx     = '0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (wr_en) begin
            if (row_ptr == LAST_ROW) begin
              ptr_nx   = '0;
              state_nx = FULL;
            end else begin
              ptr_nx   = row_ptr + 1'b1;
              state_nx = LOAD;
            end
          end
        end
        FULL: begin
          if (start) begin
            state_nx = FEED;
            k_nx     = '0;
            step_en  = 1'b1;
          end
        end
        FEED: begin
          if (k == LAST_K) begin
`ifdef MATRIX_FEEDER_REPLAY_EN
            state_nx = FULL;
`else
            state_nx = IDLE;
`endif
            k_nx    = '0;
            done_nx = 1'b1;
          end else begin
            k_nx    = k + 1'b1;
            step_en = 1'b1;
            step    = k + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem <= '0;
    else if (wr_en) mem[row_ptr] <= bus.load_row;
  end

`ifdef MATRIX_FEEDER_REPLAY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          replay_count <= '0;
    else if (clear || wr_en)               replay_count <= '0;
    else if (done_nx && replay_count != 8'hFF) replay_count <= replay_count + 8'd1;
  end
`endif

  for (genvar i = 0; i < ARRAY_W; i++) begin : g_lane
    matrix_a_feeder_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ARRAY_L   (ARRAY_L),
      .KW        (KW),
      .ROW       (i)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .step_en(step_en),
      .step   (step),
      .row    (mem[i]),
      .data   (lane_data[i]),
      .valid  (lane_vld[i])
    );
  end

  assign bus.feed_data  = lane_data;
  assign bus.feed_valid = lane_vld;
endmodule

// File: tb/tb_matrix_a_feeder.sv
// Directed bench for matrix_a_feeder (5x2 main instance, 1x1 corner instance);
// honours MATRIX_FEEDER_REPLAY_EN when defined.
module tb_matrix_a_feeder;
  localparam int DW = 8, W = 5, L = 2, N = W + L - 1;

  logic clk = 1'b0, reset_n = 1'b0;
  logic clear = 1'b0, start = 1'b0, clear1 = 1'b0, start1 = 1'b0;
  logic busy, full, done, busy1, full1, done1;
`ifdef MATRIX_FEEDER_REPLAY_EN
  logic [7:0] replay_count, replay_count1;
`endif
  int n_cmp = 0, n_err = 0;

  logic [W*DW-1:0] exp_data [N] = '{40'h0000000001, 40'h0000000302, 40'h0000050400,
                                    40'h0007060000, 40'h0908000000, 40'h0a00000000};
  logic [W-1:0]    exp_vld  [N] = '{5'b00001, 5'b00011, 5'b00110,
                                    5'b01100, 5'b11000, 5'b10000};

  matrix_a_feeder_if #(.DATA_WIDTH(DW), .ARRAY_W(W), .ARRAY_L(L)) bus ();
  matrix_a_feeder_if #(.DATA_WIDTH(DW), .ARRAY_W(1), .ARRAY_L(1)) bus1 ();

  matrix_a_feeder #(.DATA_WIDTH(DW), .ARRAY_W(W), .ARRAY_L(L)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start(start),
    .busy(busy), .full(full), .done(done),
`ifdef MATRIX_FEEDER_REPLAY_EN
    .replay_count(replay_count),
`endif
    .bus(bus)
  );

  matrix_a_feeder #(.DATA_WIDTH(DW), .ARRAY_W(1), .ARRAY_L(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .clear(clear1), .start(start1),
    .busy(busy1), .full(full1), .done(done1),
`ifdef MATRIX_FEEDER_REPLAY_EN
    .replay_count(replay_count1),
`endif
    .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [L*DW-1:0] row_of(input int i);
    return {8'(2*i + 2), 8'(2*i + 1)};
  endfunction

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // gap: idle cycle with junk on load_row between beats; start_at3: start
  // alone in LOAD, then start together with the 4th beat
  task automatic load_all(input bit gap, input bit start_at3);
    for (int i = 0; i < W; i++) begin
      if (start_at3 && i == 3) begin
        bus.load_valid = 1'b0;
        start = 1'b1;
        tick();
        chk("start in LOAD busy", busy, 0);
        chk("start in LOAD full", full, 0);
      end
      bus.load_valid = 1'b1;
      bus.load_row   = row_of(i);
      chk($sformatf("load_ready beat%0d", i), bus.load_ready, 1);
      tick();
      start = 1'b0;
      if (i < W - 1) begin
        chk($sformatf("not full after beat%0d", i), full, 0);
        if (gap) begin
          bus.load_valid = 1'b0;
          bus.load_row   = '1;
          tick();
        end
      end
    end
    bus.load_valid = 1'b0;
    chk("full after load", full, 1);
    chk("load_ready after load", bus.load_ready, 0);
  endtask

  task automatic do_feed(input bit start_mid);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < N; b++) begin
      chk($sformatf("beat%0d data", b), bus.feed_data, exp_data[b]);
      chk($sformatf("beat%0d valid", b), bus.feed_valid, exp_vld[b]);
      chk($sformatf("beat%0d busy", b), busy, 1);
      chk($sformatf("beat%0d done", b), done, 0);
      if (start_mid && b == 2) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("done pulse", done, 1);
    chk("valid after feed", bus.feed_valid, 0);
    chk("data after feed", bus.feed_data, 0);
    chk("busy after feed", busy, 0);
`ifdef MATRIX_FEEDER_REPLAY_EN
    chk("load_ready after feed", bus.load_ready, 0);
    chk("full after feed", full, 1);
`else
    chk("load_ready after feed", bus.load_ready, 1);
    chk("full after feed", full, 0);
`endif
    tick();
    chk("done one cycle", done, 0);
  endtask

  initial begin
    bus.load_valid  = 1'b0;
    bus.load_row    = '0;
    bus1.load_valid = 1'b0;
    bus1.load_row   = '0;
    #1;
    chk("rst load_ready", bus.load_ready, 1);
    chk("rst full", full, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst feed_valid", bus.feed_valid, 0);
    chk("rst feed_data", bus.feed_data, 0);
    repeat (2) tick();
    reset_n = 1'b1;

    // start in IDLE is dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start in IDLE busy", busy, 0);
    chk("start in IDLE load_ready", bus.load_ready, 1);

    load_all(1'b0, 1'b0);
    do_feed(1'b0);
`ifdef MATRIX_FEEDER_REPLAY_EN
    chk("replay_count 1", replay_count, 1);
    do_feed(1'b0);
    chk("replay_count 2", replay_count, 2);
`endif

    // every-other-cycle load, start in LOAD and mid-feed
    do_clear();
`ifdef MATRIX_FEEDER_REPLAY_EN
    chk("replay_count clear", replay_count, 0);
`endif
    load_all(1'b1, 1'b1);
    do_feed(1'b1);

    // clear at feed beat 2
    do_clear();
    load_all(1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("pre-clear beat%0d valid", b), bus.feed_valid, exp_vld[b]);
      if (b < 2) tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear feed_valid", bus.feed_valid, 0);
    chk("clear busy", busy, 0);
    chk("clear load_ready", bus.load_ready, 1);
    chk("clear done", done, 0);
    tick();
    chk("clear no done", done, 0);
    load_all(1'b0, 1'b0);
    do_feed(1'b0);

    // async reset mid-load at row_ptr=3
    do_clear();
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1'b1;
      bus.load_row   = 16'hEEEE;
      tick();
    end
    bus.load_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst mid-load load_ready", bus.load_ready, 1);
    chk("rst mid-load full", full, 0);
    reset_n = 1'b1;
    load_all(1'b0, 1'b0);
    do_feed(1'b0);

    // async reset mid-feed
    do_clear();
    load_all(1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre-reset beat1 valid", bus.feed_valid, exp_vld[1]);
    #2 reset_n = 1'b0;
    #1;
    chk("rst mid-feed valid", bus.feed_valid, 0);
    chk("rst mid-feed data", bus.feed_data, 0);
    chk("rst mid-feed busy", busy, 0);
    reset_n = 1'b1;
    tick();
    chk("rst mid-feed no done", done, 0);

    // 1x1 corner: feed length 1
    bus1.load_valid = 1'b1;
    bus1.load_row   = 8'h5a;
    tick();
    bus1.load_valid = 1'b0;
    chk("1x1 full", full1, 1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("1x1 beat data", bus1.feed_data, 8'h5a);
    chk("1x1 beat valid", bus1.feed_valid, 1);
    chk("1x1 busy", busy1, 1);
    tick();
    chk("1x1 done", done1, 1);
    chk("1x1 valid after", bus1.feed_valid, 0);
    tick();
    chk("1x1 done one cycle", done1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
